// File: rtl/ann_sweep_controller.sv
// Drives top_ann across a range of image addresses. Each image result is queued
// as {timeout_flag, addr, result} in a first-word-fall-through FIFO.
module ann_sweep_controller #(
  parameter int ADDR_W  = 10,
  parameter int RES_W   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_start,
  input  logic [1:0]              cmd_mode,
  input  logic [ADDR_W-1:0]       cmd_first_addr,
  input  logic [ADDR_W-1:0]       cmd_count,
  input  logic                    cmd_abort,
  output logic                    busy,
  output logic                    ann_start,
  output logic [ADDR_W-1:0]       ann_addr,
  input  logic                    ann_done,
  input  logic [RES_W-1:0]        ann_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ADDR_W+RES_W:0]   res_data,
  output logic [$clog2(DEPTH):0]  res_level,
  output logic                    sweep_done
);
  localparam int DW = ADDR_W + RES_W + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW:0]       FULL_LVL   = (PW+1)'(DEPTH);
  localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
  localparam logic [1:0]        MODE_SWEEP = 2'd1;
  localparam logic [1:0]        MODE_CONT  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_STALL, S_FINISH} state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   first_q, cfg_count_q, cur_addr_q, remain_q, ann_addr_q;
  logic [TW-1:0]       tmo_q;
  logic                abort_q, done_prev_q, flag_q, ann_start_q, sweep_done_q;
  logic [RES_W-1:0]    res_q;

  logic [DW-1:0]       mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         level_q, level_d;
  logic                push, pop, fifo_full, done_rise;

  // A level-style done_processing left high from the previous image must not
  // complete the next one, so only a rising edge is accepted.
  assign done_rise = ann_done && !done_prev_q;

  assign fifo_full = (level_q == FULL_LVL);
  assign pop       = res_valid && res_ready;
  assign push      = (state_q == S_STORE || state_q == S_STALL) && (!fifo_full || pop);

  assign busy       = (state_q != S_IDLE);
  assign ann_start  = ann_start_q;
  assign ann_addr   = ann_addr_q;
  assign sweep_done = sweep_done_q;
  assign res_valid  = (level_q != '0);
  assign res_level  = level_q;
  assign res_data   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      first_q      <= '0;
      cfg_count_q  <= '0;
      cur_addr_q   <= '0;
      remain_q     <= '0;
      ann_addr_q   <= '0;
      tmo_q        <= '0;
      abort_q      <= 1'b0;
      done_prev_q  <= 1'b0;
      flag_q       <= 1'b0;
      res_q        <= '0;
      ann_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      ann_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      done_prev_q  <= ann_done;
      if (state_q != S_IDLE && cmd_abort) abort_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (cmd_start) begin
            mode_q      <= cmd_mode;
            first_q     <= cmd_first_addr;
            cfg_count_q <= (cmd_count == '0) ? ONE : cmd_count;
            remain_q    <= (cmd_count == '0) ? ONE : cmd_count;
            cur_addr_q  <= cmd_first_addr;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ann_start_q <= 1'b1;
          ann_addr_q  <= cur_addr_q;
          tmo_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (done_rise) begin
            res_q   <= ann_result;
            flag_q  <= 1'b0;
            state_q <= S_STORE;
          end else if (tmo_q == TMO_LAST) begin
            res_q   <= '0;
            flag_q  <= 1'b1;
            state_q <= S_STORE;
          end
        end
        S_STORE, S_STALL: begin
          if (!push) begin
            state_q <= S_STALL;
          end else if (abort_q || cmd_abort ||
                       !(mode_q == MODE_SWEEP || mode_q == MODE_CONT) ||
                       (mode_q == MODE_SWEEP && remain_q == ONE)) begin
            state_q      <= S_FINISH;
            sweep_done_q <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
            // Continuous mode restarts the window instead of finishing.
            if (mode_q == MODE_CONT && remain_q == ONE) begin
              cur_addr_q <= first_q;
              remain_q   <= cfg_count_q;
            end else begin
              cur_addr_q <= cur_addr_q + 1'b1;
              remain_q   <= remain_q - 1'b1;
            end
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {flag_q, ann_addr_q, res_q};
  end

endmodule

// File: tb/tb_ann_sweep_controller.sv
// Randomised bench for ann_sweep_controller: a behavioural top_ann responder and
// an address/result scoreboard derived from the command parameters.
module tb_ann_sweep_controller;
  localparam int ADDR_W  = 10;
  localparam int RES_W   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int DW      = ADDR_W + RES_W + 1;
  localparam int NEVER   = 1000;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_start = 1'b0, cmd_abort = 1'b0, ann_done = 1'b0, res_ready = 1'b0;
  logic [1:0] cmd_mode = '0;
  logic [ADDR_W-1:0] cmd_first_addr = '0, cmd_count = '0;
  logic [RES_W-1:0] ann_result = '0;
  logic busy, ann_start, res_valid, sweep_done;
  logic [ADDR_W-1:0] ann_addr;
  logic [DW-1:0] res_data;
  logic [$clog2(DEPTH):0] res_level;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, starts = 0, pops = 0, done_pulses = 0, done_cyc = 0;
  int resp_delay = -1, resp_res = -1, rdy_mode = 0;
  bit allow_never = 1'b0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DW-1:0] sb[$];

  ann_sweep_controller #(.ADDR_W(ADDR_W), .RES_W(RES_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_first_addr(cmd_first_addr), .cmd_count(cmd_count), .cmd_abort(cmd_abort),
    .busy(busy), .ann_start(ann_start), .ann_addr(ann_addr), .ann_done(ann_done),
    .ann_result(ann_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_level(res_level), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Consumer ready pattern: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // top_ann model: answers each start after d cycles; d >= TIMEOUT means the
  // controller gives up first and must store a flagged zero result.
  initial begin
    int d;
    logic [RES_W-1:0] r;
    logic [ADDR_W-1:0] ea;
    forever begin
      @(negedge clk);
      if (ann_start && !reset) begin
        starts++;
        check_eq("start_expected", exp_addr.size() != 0, 1);
        ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : ann_addr;
        check_eq("ann_addr", ann_addr, ea);
        r = (resp_res >= 0) ? RES_W'(resp_res) : RES_W'($urandom);
        if (resp_delay >= 0) d = resp_delay;
        else if (allow_never && $urandom_range(0, 9) == 0) d = NEVER;
        else d = $urandom_range(0, TIMEOUT - 1);
        if (d <= TIMEOUT - 1) sb.push_back({1'b0, ea, r});
        else sb.push_back({1'b1, ea, {RES_W{1'b0}}});
        if (d < NEVER) begin
          repeat (d) @(negedge clk);
          ann_result = r;
          ann_done   = 1'b1;
          done_cyc   = cyc;
          @(negedge clk);
          ann_done   = 1'b0;
          ann_result = RES_W'($urandom);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        pops++;
        $display("pop %0d: flag=%0d addr=%0d result=%h", pops, res_data[DW-1],
                 res_data[DW-2:RES_W], res_data[RES_W-1:0]);
        check_eq("result_present", sb.size() != 0, 1);
        if (sb.size() != 0) check_eq("res_data", res_data, sb.pop_front());
      end
      if (sweep_done) done_pulses++;
    end
  end

  task automatic issue(input logic [1:0] mode, input int first, input int cnt);
    int n = (cnt == 0) ? 1 : cnt;
    pops = 0;
    starts = 0;
    if (mode == 2'd1)
      for (int i = 0; i < n; i++) exp_addr.push_back(ADDR_W'((first + i) % (1 << ADDR_W)));
    else if (mode == 2'd2)
      for (int i = 0; i < 4 * n; i++) exp_addr.push_back(ADDR_W'((first + i % n) % (1 << ADDR_W)));
    else
      exp_addr.push_back(ADDR_W'(first));
    cmd_mode = mode;
    cmd_first_addr = ADDR_W'(first);
    cmd_count = ADDR_W'(cnt);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget, input int exp_n);
    int i = 0;
    while (!sweep_done && i < budget) begin tick(); i++; end
    check_eq({tag, "_sweep_done"}, sweep_done, 1);
    check_eq({tag, "_pushed"}, pops + int'(res_level), exp_n);
    check_eq({tag, "_starts"}, starts, exp_n);
    tick();
    check_eq({tag, "_done_width"}, sweep_done, 0);
    check_eq({tag, "_idle"}, busy, 0);
    exp_addr.delete();
  endtask

  task automatic drain(input string tag);
    int i = 0;
    rdy_mode = 1;
    while ((sb.size() != 0 || res_valid) && i < 300) begin tick(); i++; end
    check_eq({tag, "_drained"}, res_valid, 0);
    check_eq({tag, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic abort_at(input int k);
    int seen = 0;
    for (int i = 0; i < 2000 && seen < k; i++) begin
      tick();
      if (ann_start) seen++;
    end
    check_eq("abort_reached", seen, k);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
  endtask

  initial begin
    int s, i, snap, n, k;
    logic [1:0] m;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ann_start", ann_start, 0);
    check_eq("rst_ann_addr", ann_addr, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_level", res_level, 0);
    check_eq("rst_sweep_done", sweep_done, 0);
    reset = 1'b0;
    tick();

    // Single image, result 3F after 10 cycles, consumer stalled.
    resp_delay = 10; resp_res = 8'h3F;
    issue(2'd0, 5, 0);
    check_eq("start_lat_1", ann_start, 0);
    tick();
    check_eq("start_lat_2", ann_start, 1);
    check_eq("single_addr", ann_addr, 5);
    check_eq("single_busy", busy, 1);
    i = 0;
    while (!res_valid && i < 100) begin tick(); i++; end
    check_eq("done_to_valid", cyc - done_cyc, 2);
    check_eq("single_level", res_level, 1);
    wait_finish("single", 100, 1);
    drain("single");

    // Sweep wrapping past 1023 with a stalled consumer, plus a start while busy.
    resp_delay = -1; resp_res = -1; rdy_mode = 0;
    issue(2'd1, 1020, 8);
    repeat (3) tick();
    cmd_mode = 2'd0; cmd_first_addr = 10'd99; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (150) tick();
    check_eq("bp_level", res_level, DEPTH);
    check_eq("bp_starts_held", starts, DEPTH + 1);
    check_eq("bp_busy", busy, 1);
    rdy_mode = 1;
    wait_finish("bp", 600, 8);
    drain("bp");

    // No response at all: flagged results, sweep moves on.
    resp_delay = NEVER;
    issue(2'd1, 200, 2);
    i = 0;
    while (!ann_start && i < 10) begin tick(); i++; end
    s = cyc;
    i = 0;
    while (!res_valid && i < 40) begin tick(); i++; end
    check_eq("timeout_lat", cyc - s, TIMEOUT + 1);
    rdy_mode = 1;
    wait_finish("tmo", 100, 2);
    drain("tmo");

    // Answer in the last waiting cycle wins; one cycle later is too late.
    resp_delay = TIMEOUT - 1;
    issue(2'd0, 300, 0);
    wait_finish("coinc", 100, 1);
    drain("coinc");
    resp_delay = TIMEOUT;
    issue(2'd0, 301, 0);
    wait_finish("late", 100, 1);
    drain("late");

    // Abort in IDLE is ignored; count 0 runs one image.
    resp_delay = -1;
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    issue(2'd1, 50, 0);
    wait_finish("cnt0", 100, 1);
    drain("cnt0");

    // Continuous 7,8,9,... aborted while waiting on address 8.
    issue(2'd2, 7, 3);
    abort_at(2);
    wait_finish("cont", 100, 2);
    drain("cont");

    // Random commands with random backpressure and occasional timeouts.
    allow_never = 1'b1;
    for (int t = 0; t < 14; t++) begin
      m = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 5);
      rdy_mode = 2;
      issue(m, $urandom_range(0, (1 << ADDR_W) - 1), n);
      if (m == 2'd2) begin
        k = $urandom_range(1, 2 * ((n == 0) ? 1 : n));
        abort_at(k);
      end else begin
        k = (m == 2'd1) ? ((n == 0) ? 1 : n) : 1;
      end
      wait_finish("rand", 3000, k);
      drain("rand");
    end
    allow_never = 1'b0;

    // Asynchronous reset in the middle of a wait, with one result queued.
    resp_delay = NEVER; rdy_mode = 0;
    issue(2'd1, 500, 4);
    i = 0;
    while (!res_valid && i < 60) begin tick(); i++; end
    check_eq("arst_prefill", res_valid, 1);
    i = 0;
    while (!ann_start && i < 20) begin tick(); i++; end
    repeat (3) tick();
    snap = done_pulses;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ann_start", ann_start, 0);
    check_eq("arst_ann_addr", ann_addr, 0);
    check_eq("arst_res_valid", res_valid, 0);
    check_eq("arst_res_level", res_level, 0);
    check_eq("arst_sweep_done", sweep_done, 0);
    sb.delete();
    exp_addr.delete();
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    check_eq("arst_no_done", done_pulses, snap);
    check_eq("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
